alu_pipe_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_iter_muldiv.sv | 76 +++++++
 rtl/alu_pipe_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_pipe_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and flag indices shared by the ALU pipe stage
// Purpose: the opcode map, the IDLE/BUSY/DONE state type, flag bit positions
//          and a helper that classifies opcodes using the iterative datapath.
// Ports:   none (package).
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_ANDN = 4'h5;
    localparam logic [3:0] OP_ORN  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_PASA = 4'h8;
    localparam logic [3:0] OP_PASB = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_DIVU = 4'hD;
    localparam logic [3:0] OP_REMU = 4'hE;
    localparam logic [3:0] OP_SLTU = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_ZF   = 0;
    localparam int FLAG_EF   = 1;
    localparam int FLAG_CF   = 2;
    localparam int FLAG_VF   = 3;
    localparam int FLAG_NF   = 4;
    localparam int FLAG_DZF  = 5;
    localparam int NUM_FLAGS = 6;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - shared shift-add multiplier / restoring divider
// Purpose: WIDTH-step iterative MUL (low half) and DIVU/REMU on one register set.
// Ports:   clk, rst_n (async active-low); start, is_div, a, b load an operation;
//          done is high in the cycle whose step completes it; quo_prod and rem
//          are the values after that step; dz flags a divide by zero.
module alu_iter_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] quo_prod,
    output logic [WIDTH-1:0] rem
);

    localparam int CW = $clog2(WIDTH + 1);

    // MUL: a_q = shifted multiplicand, b_q = shifted multiplier, r_q = accumulator.
    // DIV: a_q = dividend shifting out / quotient shifting in, b_q = divisor, r_q = remainder.
    logic [WIDTH-1:0] a_q, b_q, r_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q, dz_q;

    logic [WIDTH:0]   shifted, diff;
    logic             ge;
    logic [WIDTH-1:0] rem_n, quo_n, acc_n;

    always_comb begin
        shifted = {r_q, a_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        ge      = (shifted >= {1'b0, b_q});
        rem_n   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_n   = {a_q[WIDTH-2:0], ge};
        acc_n   = r_q + (b_q[0] ? a_q : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
            dz_q  <= 1'b0;
        end else if (start) begin
            a_q   <= a;
            b_q   <= b;
            r_q   <= '0;
            div_q <= is_div;
            dz_q  <= is_div && (b == '0);
            // A zero divisor needs no iterations: a single BUSY cycle.
            cnt_q <= (is_div && (b == '0)) ? CW'(1) : CW'(WIDTH);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            if (div_q) begin
                a_q <= quo_n;
                r_q <= rem_n;
            end else begin
                a_q <= a_q << 1;
                b_q <= b_q >> 1;
                r_q <= acc_n;
            end
        end
    end

    assign done     = (cnt_q == CW'(1));
    assign dz       = dz_q;
    assign quo_prod = dz_q ? '1 : (div_q ? quo_n : acc_n);
    assign rem      = dz_q ? a_q : rem_n;

endmodule

// File: rtl/alu_pipe_seq.sv
// rtl/alu_pipe_seq.sv - registered ALU stage with valid/ready handshakes
// Purpose: 1-cycle ADD/SUB/logic/move/shift/SLTU, iterative MUL/DIVU/REMU,
//          with zero/equal/carry/overflow/negative/divide-by-zero flags.
// Ports:   clk, rst_n (async active-low); in_valid/in_ready with op1, op2,
//          op_code; out_valid/out_ready with out, zf, ef, cf, vf, nf, dzf.
import alu_pkg::*;

module alu_pipe_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zf,
    output logic             ef,
    output logic             cf,
    output logic             vf,
    output logic             nf,
    output logic             dzf
);

    localparam int SHW = $clog2(WIDTH);

    state_t               state_q, state_d;
    logic                 ready_c, accept, iter_start;
    logic [3:0]           op_q;
    logic                 ef_pend;
    logic [WIDTH-1:0]     out_q;
    logic [NUM_FLAGS-1:0] flags_q, sc_flags, it_flags;

    logic [WIDTH:0]       add_ext, sub_ext;
    logic                 shift_oob;
    logic [WIDTH-1:0]     sc_res, it_res;
    logic                 sc_cf, sc_vf;

    logic                 it_done, it_dz;
    logic [WIDTH-1:0]     it_quo_prod, it_rem;

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (iter_start),
        .is_div   (op_code != OP_MUL),
        .a        (op1),
        .b        (op2),
        .done     (it_done),
        .dz       (it_dz),
        .quo_prod (it_quo_prod),
        .rem      (it_rem)
    );

    // Zero-extended so bit WIDTH is the ADD carry and the SUB borrow (op1 < op2).
    assign add_ext   = {1'b0, op1} + {1'b0, op2};
    assign sub_ext   = {1'b0, op1} - {1'b0, op2};
    // The whole op2 is compared so large amounts are not aliased by truncation.
    assign shift_oob = (op2 >= WIDTH'(WIDTH));

    always_comb begin
        sc_res = '0;
        sc_cf  = 1'b0;
        sc_vf  = 1'b0;
        case (op_code)
            OP_ADD: begin
                sc_res = add_ext[WIDTH-1:0];
                sc_cf  = add_ext[WIDTH];
                sc_vf  = (op1[WIDTH-1] == op2[WIDTH-1]) && (add_ext[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_ext[WIDTH-1:0];
                sc_cf  = sub_ext[WIDTH];
                sc_vf  = (op1[WIDTH-1] != op2[WIDTH-1]) && (sub_ext[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_AND:  sc_res = op1 & op2;
            OP_OR:   sc_res = op1 | op2;
            OP_XOR:  sc_res = op1 ^ op2;
            OP_ANDN: sc_res = op1 & ~op2;
            OP_ORN:  sc_res = op1 | ~op2;
            OP_XNOR: sc_res = ~(op1 ^ op2);
            OP_PASA: sc_res = op1;
            OP_PASB: sc_res = op2;
            OP_SHL:  sc_res = shift_oob ? '0 : (op1 << op2[SHW-1:0]);
            OP_SHR:  sc_res = shift_oob ? '0 : (op1 >> op2[SHW-1:0]);
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, sub_ext[WIDTH]};
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        sc_flags            = '0;
        sc_flags[FLAG_ZF]   = (sc_res == '0);
        sc_flags[FLAG_EF]   = (op1 == op2);
        sc_flags[FLAG_CF]   = sc_cf;
        sc_flags[FLAG_VF]   = sc_vf;
        sc_flags[FLAG_NF]   = sc_res[WIDTH-1];

        it_res              = (op_q == OP_REMU) ? it_rem : it_quo_prod;
        it_flags            = '0;
        it_flags[FLAG_ZF]   = (it_res == '0);
        it_flags[FLAG_EF]   = ef_pend;
        it_flags[FLAG_NF]   = it_res[WIDTH-1];
        it_flags[FLAG_DZF]  = it_dz;
    end

    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        case (state_q)
            ST_IDLE: ready_c = 1'b1;
            ST_BUSY: if (it_done) state_d = ST_DONE;
            ST_DONE: begin
                // Retiring and accepting in the same cycle keeps 1/clk throughput.
                ready_c = out_ready;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        accept     = in_valid && ready_c;
        iter_start = accept && is_iter_op(op_code);
        if (accept) state_d = is_iter_op(op_code) ? ST_BUSY : ST_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            ef_pend <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op_code;
                ef_pend <= (op1 == op2);
                if (!is_iter_op(op_code)) begin
                    out_q   <= sc_res;
                    flags_q <= sc_flags;
                end
            end else if (state_q == ST_BUSY && it_done) begin
                out_q   <= it_res;
                flags_q <= it_flags;
            end
        end
    end

    assign in_ready  = ready_c && rst_n;
    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign zf        = flags_q[FLAG_ZF];
    assign ef        = flags_q[FLAG_EF];
    assign cf        = flags_q[FLAG_CF];
    assign vf        = flags_q[FLAG_VF];
    assign nf        = flags_q[FLAG_NF];
    assign dzf       = flags_q[FLAG_DZF];

endmodule

// File: tb/tb_alu_pipe_seq.sv
// tb/tb_alu_pipe_seq.sv - scoreboard bench for alu_pipe_seq at WIDTH=8
module tb_alu_pipe_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic [3:0]   op_code = '0;
    logic         in_ready, out_valid, zf, ef, cf, vf, nf, dzf;
    logic [W-1:0] out;

    alu_pipe_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .op_code   (op_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zf        (zf),
        .ef        (ef),
        .cf        (cf),
        .vf        (vf),
        .nf        (nf),
        .dzf       (dzf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Flags packed as {dzf, nf, vf, cf, ef, zf}.
    typedef struct {
        logic [W-1:0] res;
        logic [5:0]   fl;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   last_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got out=%0h with empty scoreboard", out);
            end else begin
                mon_e = sb.pop_front();
                check("out", 32'(out), 32'(mon_e.res));
                check("flags", 32'({dzf, nf, vf, cf, ef, zf}), 32'(mon_e.fl));
                if (mon_e.lat != 0)
                    check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eo, input logic [5:0] efl, input int lat);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        op_code  = op;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: op=%0h in_ready=%0b required 1", op, in_ready);
            in_valid = 1'b0;
            return;
        end
        e.res = eo;
        e.fl  = efl;
        e.lat = lat;
        e.acc = cyc;
        last_acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op1      = 8'($urandom);
        op2      = 8'($urandom);
        op_code  = 4'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eo;
        logic [5:0]   fl;
        int           lat;
    } vec_t;

    vec_t vecs[] = '{
        '{4'h0, 8'hF0, 8'h20, 8'h10, 6'b000100, 1},   // ADD carry out
        '{4'h1, 8'h05, 8'h05, 8'h00, 6'b000011, 1},   // SUB equal
        '{4'h1, 8'h7F, 8'hFF, 8'h80, 6'b011100, 1},   // SUB overflow + borrow
        '{4'h2, 8'hF0, 8'h3C, 8'h30, 6'b000000, 1},   // AND
        '{4'h5, 8'hF0, 8'h30, 8'hC0, 6'b010000, 1},   // op1 & ~op2
        '{4'h6, 8'h00, 8'h0F, 8'hF0, 6'b010000, 1},   // op1 | ~op2
        '{4'h7, 8'hAA, 8'hAA, 8'hFF, 6'b010010, 1},   // XNOR
        '{4'h9, 8'h12, 8'h34, 8'h34, 6'b000000, 1},   // pass op2
        '{4'hA, 8'h01, 8'h09, 8'h00, 6'b000001, 1},   // SHL by 9
        '{4'hA, 8'h01, 8'h07, 8'h80, 6'b010000, 1},   // SHL by 7
        '{4'hA, 8'h01, 8'h08, 8'h00, 6'b000001, 1},   // SHL by WIDTH
        '{4'hB, 8'h80, 8'h07, 8'h01, 6'b000000, 1},   // SHR by 7
        '{4'hB, 8'h80, 8'hFF, 8'h00, 6'b000001, 1},   // SHR by 255, no truncation
        '{4'hF, 8'h03, 8'h05, 8'h01, 6'b000000, 1},   // SLTU true
        '{4'hF, 8'h05, 8'h03, 8'h00, 6'b000001, 1},   // SLTU false
        '{4'hC, 8'hFF, 8'hFF, 8'h01, 6'b000010, 9},   // MUL low byte of FE01
        '{4'hC, 8'h10, 8'h10, 8'h00, 6'b000011, 9},   // MUL wraps to zero
        '{4'hD, 8'h64, 8'h07, 8'h0E, 6'b000000, 9},   // DIVU 100/7
        '{4'hE, 8'h64, 8'h07, 8'h02, 6'b000000, 9},   // REMU 100%7
        '{4'hD, 8'h64, 8'h00, 8'hFF, 6'b110000, 2},   // DIVU by zero
        '{4'hE, 8'h64, 8'h00, 8'h64, 6'b100000, 2},   // REMU by zero
        '{4'hD, 8'hFF, 8'h01, 8'hFF, 6'b010000, 9},   // DIVU by one
        '{4'hD, 8'h05, 8'h09, 8'h00, 6'b000001, 9}    // DIVU smaller dividend
    };

    logic [W-1:0] xor_a[10] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    logic [W-1:0] xor_e[10] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h88, 8'h77, 8'h66};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        int pulses;

        repeat (2) @(negedge clk);
        check("reset_out", 32'(out), 32'd0);
        check("reset_flags", 32'({dzf, nf, vf, cf, ef, zf}), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i])
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eo, vecs[i].fl, vecs[i].lat);
        drain();

        // MUL with in_ready held low for all BUSY cycles.
        issue(4'hC, 8'h0F, 8'h11, 8'hFF, 6'b010000, 9);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("busy_in_ready", 32'(in_ready), 32'd0);
        end
        drain();

        // Consumer stalls for 3 cycles in DONE.
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(4'h0, 8'h40, 8'h40, 8'h80, 6'b011010, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out", 32'(out), 32'h80);
            check("stall_flags", 32'({dzf, nf, vf, cf, ef, zf}), 32'b011010);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Ten XORs with no gap between accepts.
        t0 = 0;
        for (int k = 0; k < 10; k++) begin
            issue(4'h4, xor_a[k], 8'hFF, xor_e[k], {1'b0, xor_e[k][7], 4'b0000}, 1);
            if (k == 0) t0 = last_acc;
        end
        check("b2b_accept_span", 32'(last_acc - t0), 32'd9);
        drain();

        // Reset in the middle of a MUL discards it.
        issue(4'hC, 8'h0F, 8'h11, 8'hFF, 6'b010000, 9);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'd0);
        check("async_rst_flags", 32'({dzf, nf, vf, cf, ef, zf}), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("no_pulse_after_reset", 32'(pulses), 32'd0);
        issue(4'h0, 8'h01, 8'h01, 8'h02, 6'b000010, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
